fetch_unit: RTL and testbench

- Parametrised instruction-fetch front end for the 5-stage RISC pipeline; replaces the bare PC/adder/PC-mux/IF-ID chain.
- Issues sequential fetch requests over a valid/ready instruction-memory port and keeps up to DEPTH requests in flight.
- Buffers responses in an in-order prefetch FIFO, presents {pc, instr} to ID under hazard stall, and flushes cleanly on branch/jump redirect from MEM.

---
 rtl/risc_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/fetch_unit.sv | 130 +++++++++++++
 tb/tb_fetch_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared definitions for the RISC front end.
//   - Default PC/instruction widths and the post-reset fetch address.
//   - FETCH_ENTRY_W(xlen, ilen): width of one packed {pc, instr} fetch entry.
// No ports; this file is imported by fetch_fifo and fetch_unit.
`ifndef RISC_PKG_SV
`define RISC_PKG_SV

`define FETCH_ENTRY_W(xlen, ilen) ((xlen) + (ilen))

package risc_pkg;
    localparam int          XLEN_DEF     = 32;
    localparam int          ILEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
endpackage

`endif

// File: rtl/fetch_fifo.sv
// In-order prefetch FIFO of packed {pc, instr} entries.
// Ports:
//   clk        rising-edge clock
//   clr        asynchronous active-high reset (empties the FIFO)
//   push       write push_data at the tail
//   push_data  entry to write
//   pop        drop the head entry (caller only pops when count != 0)
//   flush      empty the FIFO; overrides push and pop in the same cycle
//   count      number of valid entries (0..DEPTH)
//   head       entry at the head; contents undefined when count == 0
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
    import risc_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int W     = `FETCH_ENTRY_W(XLEN_DEF, ILEN_DEF),
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output logic [W-1:0]  head
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            // push together with pop leaves the occupancy unchanged
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: sequential fetch over a valid/ready memory
// port with up to DEPTH requests in flight, in-order prefetch buffering,
// hazard stall hold and branch/jump redirect with stale-response discard.
// Ports:
//   clk, clr                       clock, asynchronous active-high reset
//   imem_req_valid/addr/ready      fetch request channel
//   imem_rsp_valid/data            in-order fetch responses, one per accepted request
//   redirect_valid/pc              taken branch/jump from MEM; highest priority
//   stall                          hazard stall from ID; holds the output entry
//   if_valid/pc/instr              head instruction presented to ID (zero when empty)
// Build option:
//   FETCH_BYPASS_EN  when defined, a response arriving at an empty FIFO with
//                    nothing to discard is shown to ID in the same cycle and,
//                    if ID is not stalled, consumed without entering the FIFO.
module fetch_unit
    import risc_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              ILEN     = ILEN_DEF,
    parameter int              DEPTH    = 4,
    parameter int              PC_STEP  = 1,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            clr,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [ILEN-1:0] if_instr
);

    localparam int CW  = $clog2(DEPTH + 1);
    localparam int CWP = CW + 1;
    localparam int EW  = `FETCH_ENTRY_W(XLEN, ILEN);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   fifo_cnt;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   inflight_nxt;
    logic [CW-1:0]   kill;
    logic [CWP-1:0]  credit_used;
    logic [EW-1:0]   head;
    logic            fifo_empty;
    logic            accept;
    logic            rsp_fire;
    logic            rsp_keep;
    logic            bypass;
    logic            push;
    logic            pop;

    // Every outstanding request that will not be discarded owns a FIFO slot,
    // so a kept response can always be written.
    assign credit_used    = CWP'(fifo_cnt) + CWP'(inflight) - CWP'(kill);
    assign imem_req_valid = ~clr & ~redirect_valid & (credit_used < CWP'(DEPTH));
    assign imem_req_addr  = fetch_pc;

    assign accept       = imem_req_valid & imem_req_ready;
    assign rsp_fire     = imem_rsp_valid & (inflight != '0);  // stray responses ignored
    assign rsp_keep     = rsp_fire & (kill == '0);
    assign inflight_nxt = inflight + CW'(accept) - CW'(rsp_fire);
    assign fifo_empty   = (fifo_cnt == '0);

`ifdef FETCH_BYPASS_EN
    assign bypass = rsp_keep & fifo_empty;
`else
    assign bypass = 1'b0;
`endif

    // A redirect flushes the FIFO, so any pop or push in that cycle is moot.
    assign pop  = ~fifo_empty & ~stall & ~redirect_valid;
    assign push = rsp_keep & ~(bypass & ~stall) & ~redirect_valid;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk       (clk),
        .clr       (clr),
        .push      (push),
        .push_data ({rsp_pc, imem_rsp_data}),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (fifo_cnt),
        .head      (head)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            kill     <= '0;
        end else begin
            inflight <= inflight_nxt;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                rsp_pc   <= redirect_pc;
                // everything still outstanding after this cycle is stale
                kill     <= inflight_nxt;
            end else begin
                if (accept)                        fetch_pc <= fetch_pc + XLEN'(PC_STEP);
                if (rsp_keep)                      rsp_pc   <= rsp_pc + XLEN'(PC_STEP);
                if (rsp_fire && (kill != '0))      kill     <= kill - CW'(1);
            end
        end
    end

    always_comb begin
        if_valid = 1'b0;
        if_pc    = '0;
        if_instr = '0;
        if (!fifo_empty) begin
            if_valid          = 1'b1;
            {if_pc, if_instr} = head;
        end else if (bypass) begin
            if_valid = 1'b1;
            if_pc    = rsp_pc;
            if_instr = imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk;
    logic        clr;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    fetch_unit #(
        .XLEN(32), .ILEN(32), .DEPTH(4), .PC_STEP(1), .RESET_PC(32'h0)
    ) dut (
        .clk            (clk),
        .clr            (clr),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [63:0] exp_q [$];
    logic [31:0] mem_q [$];
    logic        ready_s = 1'b0;
    logic        rsp_en  = 1'b0;
    logic [63:0] exp_e;

    // Instruction memory content.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        if (a == 32'h8) return 32'hDEAD_BEEF;
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic exp_push(input logic [31:0] pc, input logic [31:0] ins);
        exp_q.push_back({pc, ins});
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Memory model: drives ready/response at +1 after each falling edge,
    // records accepted addresses at +2, answers at least one cycle later.
    always @(negedge clk) begin
        #1;
        if (clr) begin
            mem_q.delete();
            imem_req_ready = 1'b0;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end else begin
            if (rsp_en && mem_q.size() != 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = instr_of(mem_q.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end
            imem_req_ready = ready_s;
            #1;
            if (imem_req_valid && imem_req_ready) mem_q.push_back(imem_req_addr);
        end
    end

    // Monitor: every entry ID consumes is checked against the scoreboard.
    always @(negedge clk) begin
        #3;
        if (!clr && if_valid && !stall) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_entry: got pc %h instr %h, required no entry", if_pc, if_instr);
            end else begin
                exp_e = exp_q.pop_front();
                if ({if_pc, if_instr} !== exp_e) begin
                    fails++;
                    $display("FAIL stream_entry: got pc %h instr %h, required pc %h instr %h",
                             if_pc, if_instr, exp_e[63:32], exp_e[31:0]);
                end
            end
        end
    end

    task automatic do_reset();
        cyc();
        clr = 1'b1; stall = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        ready_s = 1'b0; rsp_en = 1'b0;
        #4;
        check("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("rst_if_valid",  64'(if_valid), 64'd0);
        check("rst_if_pc",     64'(if_pc), 64'd0);
        exp_q.delete();
        cyc();
        cyc();
    endtask

    // Wait (bounded) until every expected entry was consumed, then stall ID.
    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            cyc(); #4; n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        cyc();
        stall = 1'b1;
    endtask

    initial begin
        clr = 1'b1; stall = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;

        // 1: reset and credits, no responses
        do_reset();
        cyc(); clr = 1'b0; ready_s = 1'b1; stall = 1'b0; #4;
        check("t1_req_valid_0", 64'(imem_req_valid), 64'd1);
        check("t1_req_addr_0",  64'(imem_req_addr), 64'd0);
        for (int i = 1; i < 4; i++) begin
            cyc(); #4;
            check("t1_req_addr", {31'd0, imem_req_valid, imem_req_addr}, {31'd0, 1'b1, 32'(i)});
        end
        cyc(); #4;
        check("t1_no_credit", 64'(imem_req_valid), 64'd0);
        check("t1_inflight",  64'(dut.inflight), 64'd4);

        // 2: streaming with 2-cycle accept-to-ID latency
        do_reset();
        for (int i = 0; i < 8; i++) exp_push(32'(i), {16'hC0DE, 16'(i)});
        cyc(); clr = 1'b0; ready_s = 1'b1; rsp_en = 1'b1; stall = 1'b0; #4;
        check("t2_c0_req", {imem_req_valid, imem_req_addr}, {1'b1, 32'h0});
        check("t2_c0_ifv", 64'(if_valid), 64'd0);
        cyc(); #4;
        check("t2_c1_ifv", 64'(if_valid), 64'd0);
        cyc(); #4;
        check("t2_c2_head", {if_valid, if_pc, if_instr}, {1'b1, 32'h0, 32'hC0DE_0000});
        drain("t2_drain");

        // 3: backpressure with a full FIFO
        do_reset();
        for (int i = 0; i < 6; i++) exp_push(32'(i), {16'hC0DE, 16'(i)});
        cyc(); clr = 1'b0; ready_s = 1'b1; rsp_en = 1'b1;
        repeat (6) cyc();
        for (int k = 0; k < 5; k++) begin
            cyc(); #4;
            check("t3_hold_head", {if_valid, if_pc}, {1'b1, 32'h0});
            check("t3_hold_noreq", 64'(imem_req_valid), 64'd0);
        end
        cyc(); stall = 1'b0; #4;
        check("t3_full_noreq", 64'(imem_req_valid), 64'd0);
        cyc(); #4;
        check("t3_resume", {imem_req_valid, imem_req_addr}, {1'b1, 32'h4});
        drain("t3_drain");

        // 4: redirect with 3 requests in flight
        do_reset();
        exp_push(32'h40, 32'hC0DE_0040); exp_push(32'h41, 32'hC0DE_0041);
        exp_push(32'h42, 32'hC0DE_0042); exp_push(32'h43, 32'hC0DE_0043);
        cyc(); clr = 1'b0; ready_s = 1'b1; stall = 1'b0;
        cyc(); cyc();
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h40; #4;
        check("t4_redir_noreq", 64'(imem_req_valid), 64'd0);
        cyc(); redirect_valid = 1'b0; rsp_en = 1'b1; #4;
        check("t4_req_target", {imem_req_valid, imem_req_addr}, {1'b1, 32'h40});
        check("t4_kill", 64'(dut.kill), 64'd3);
        drain("t4_drain");

        // 5: redirect together with a response and a pop
        do_reset();
        exp_push(32'h0, 32'hC0DE_0000);
        exp_push(32'h80, 32'hC0DE_0080); exp_push(32'h81, 32'hC0DE_0081);
        exp_push(32'h82, 32'hC0DE_0082);
        cyc(); clr = 1'b0; ready_s = 1'b1; stall = 1'b0;
        cyc(); cyc();
        cyc(); rsp_en = 1'b1;
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h80; #4;
        check("t5_head_before", {if_valid, if_pc}, {1'b1, 32'h0});
        cyc(); redirect_valid = 1'b0; #4;
        check("t5_ifv_after", 64'(if_valid), 64'd0);
        check("t5_kill", 64'(dut.kill), 64'd2);
        check("t5_inflight", 64'(dut.inflight), 64'd2);
        check("t5_req_target", {imem_req_valid, imem_req_addr}, {1'b1, 32'h80});
        drain("t5_drain");

        // 6: address hold under ready low, then response-to-ID latency
        do_reset();
        exp_push(32'h8, 32'hDEAD_BEEF);
        cyc(); clr = 1'b0; stall = 1'b0; rsp_en = 1'b1; #4;
        check("t6_hold0", {imem_req_valid, imem_req_addr}, {1'b1, 32'h0});
        cyc(); #4;
        check("t6_hold1", {imem_req_valid, imem_req_addr}, {1'b1, 32'h0});
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h8; #4;
        cyc(); redirect_valid = 1'b0; ready_s = 1'b1; #4;
        check("t6_req8", {imem_req_valid, imem_req_addr}, {1'b1, 32'h8});
        cyc(); ready_s = 1'b0; #4;
`ifdef FETCH_BYPASS_EN
        check("t6_same_cycle", {if_valid, if_pc, if_instr}, {1'b1, 32'h8, 32'hDEAD_BEEF});
        cyc(); #4;
        check("t6_next_cycle", 64'(if_valid), 64'd0);
`else
        check("t6_same_cycle", 64'(if_valid), 64'd0);
        cyc(); #4;
        check("t6_next_cycle", {if_valid, if_pc, if_instr}, {1'b1, 32'h8, 32'hDEAD_BEEF});
`endif
        drain("t6_drain");

        // 7: PC wrap-around
        do_reset();
        exp_push(32'hFFFF_FFFE, 32'hC0DE_FFFE); exp_push(32'hFFFF_FFFF, 32'hC0DE_FFFF);
        exp_push(32'h0, 32'hC0DE_0000);         exp_push(32'h1, 32'hC0DE_0001);
        cyc(); clr = 1'b0; stall = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        cyc(); redirect_valid = 1'b0; ready_s = 1'b1; rsp_en = 1'b1; #4;
        check("t7_req_wrap", {imem_req_valid, imem_req_addr}, {1'b1, 32'hFFFF_FFFE});
        drain("t7_drain");

        cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
